// File: rtl/ref_particle_issue_ctrl_if.sv
// rtl/ref_particle_issue_ctrl_if.sv - issue controller handshake and RAM-read bundle
interface ref_particle_issue_ctrl_if #(
  parameter int PARTICLE_ID_WIDTH = 7
);
  logic                         start;
  logic [PARTICLE_ID_WIDTH-1:0] particle_count;
  logic                         particle_count_valid;
  logic                         back_pressure;
  logic                         ref_rd_en;
  logic [PARTICLE_ID_WIDTH-1:0] ref_rd_addr;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id;
  logic                         ref_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output start, particle_count, particle_count_valid, back_pressure,
    input  ref_rd_en, ref_rd_addr, ref_id, ref_valid, busy, done
  );

  modport slave (
    input  start, particle_count, particle_count_valid, back_pressure,
    output ref_rd_en, ref_rd_addr, ref_id, ref_valid, busy, done
  );
endinterface

// File: rtl/ref_particle_issue_ctrl.sv
// rtl/ref_particle_issue_ctrl.sv - walks reference IDs 1..count, one position-RAM read each
module ref_particle_issue_ctrl #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int RD_LATENCY        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ref_particle_issue_ctrl_if.slave bus
);
  localparam int W = PARTICLE_ID_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_CNT, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [W:0]     id_q, id_d;
  logic [W-1:0]   count_q, count_d;
  logic           rd_en;
  logic           pending;
  logic [RD_LATENCY-1:0] vld_q;
  logic [W-1:0]   id_pipe_q [RD_LATENCY];

  // The last stage is the one currently on ref_valid; done may follow it directly.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < RD_LATENCY - 1; k++) begin
      pending = pending | vld_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    count_d = count_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_WAIT_CNT;
      end
      S_WAIT_CNT: begin
        if (bus.particle_count_valid) begin
          count_d = bus.particle_count;
          id_d    = (W+1)'(1);
          state_d = (bus.particle_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.back_pressure) begin
          rd_en = 1'b1;
          id_d  = id_q + (W+1)'(1);
          if (id_q == {1'b0, count_q}) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pending) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) id_pipe_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      count_q  <= count_d;
      vld_q[0] <= rd_en;
      if (rd_en) id_pipe_q[0] <= id_q[W-1:0];
      // ID stages load only behind a valid entry so ref_id holds between strobes.
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) id_pipe_q[k] <= id_pipe_q[k-1];
      end
    end
  end

  assign bus.ref_rd_en   = rd_en;
  assign bus.ref_rd_addr = (state_q == S_ISSUE) ? (id_q[W-1:0] - W'(1)) : '0;
  assign bus.ref_valid   = vld_q[RD_LATENCY-1];
  assign bus.ref_id      = id_pipe_q[RD_LATENCY-1];
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_ref_particle_issue_ctrl.sv
// tb/tb_ref_particle_issue_ctrl.sv - bench for ref_particle_issue_ctrl
module tb_ref_particle_issue_ctrl;
  localparam int W    = 7;
  localparam int RDL  = 2;
  localparam int MAXC = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ref_particle_issue_ctrl_if #(.PARTICLE_ID_WIDTH(W)) bus ();

  ref_particle_issue_ctrl #(.PARTICLE_ID_WIDTH(W), .RD_LATENCY(RDL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          count;
    int          pcv_delay;
    logic [31:0] bp_mask;
    bit          extra_start;
    int          exp_reads;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int failures = 0;
  int last_id = 0;

  bit s_start[MAXC];
  bit s_bp[MAXC];
  bit e_busy[MAXC], e_done[MAXC], e_rd[MAXC], e_val[MAXC];
  int e_addr[MAXC], e_id[MAXC], v_id[MAXC];
  int m_done_cyc, m_ncyc, m_lc;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: latch on first valid count after start, one read per non-stalled
  // cycle, data appears RD_LATENCY later, done the cycle after the final strobe.
  task automatic build_model(input int count, input int pd);
    int j, last, cur;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_val[c] = 0;
      e_addr[c] = 0; e_id[c] = 0; v_id[c] = 0;
    end
    m_lc = (pd < 1) ? 1 : pd;
    j = 0;
    last = m_lc;
    for (int c = m_lc + 1; c < MAXC - RDL - 8 && j < count; c++) begin
      if (!s_bp[c]) begin
        e_rd[c] = 1; e_addr[c] = j;
        e_val[c+RDL] = 1; v_id[c+RDL] = j + 1;
        j++; last = c;
      end
    end
    m_done_cyc = (count == 0) ? m_lc + 1 : last + RDL + 1;
    m_ncyc = m_done_cyc + 4;
    for (int c = 1; c <= m_done_cyc; c++) e_busy[c] = 1;
    e_done[m_done_cyc] = 1;
    cur = last_id;
    for (int c = 0; c < MAXC; c++) begin
      if (e_val[c]) cur = v_id[c];
      e_id[c] = cur;
    end
  endtask

  task automatic run_cell(input int count, input int pd, input bit extra,
                          input int run, output int n_reads, output int done_cyc);
    logic [3+2*W:0] g, e;
    logic [W-1:0] cnt_w;
    bit pcv;
    int n_done;
    build_model(count, pd);
    for (int c = 0; c < MAXC; c++)
      s_start[c] = (c == 0) || (extra && c <= m_done_cyc && $urandom_range(0, 3) == 0);
    cnt_w = W'(count);
    n_reads = 0; n_done = 0; done_cyc = -1;
    for (int c = 0; c < m_ncyc; c++) begin
      pcv = (c >= pd) && (c <= m_lc);
      bus.start = s_start[c];
      bus.back_pressure = s_bp[c];
      bus.particle_count_valid = pcv;
      bus.particle_count = pcv ? cnt_w : W'($urandom);
      @(negedge clk);
      g = {bus.busy, bus.done, bus.ref_rd_en, bus.ref_valid, bus.ref_id,
           (e_rd[c] ? bus.ref_rd_addr : W'(0))};
      e = {e_busy[c], e_done[c], e_rd[c], e_val[c], W'(e_id[c]), W'(e_addr[c])};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL cycle run=%0d c=%0d busy,done,rd,val,id,addr got=%h exp=%h",
                 run, c, g, e);
      end
      if (bus.ref_rd_en) n_reads++;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
    end
    check("done_pulses", n_done, 1);
    last_id = e_id[m_ncyc-1];
  endtask

  initial begin
    int n_reads, done_cyc, cnt, pd;
    bit extra;

    vecs[0] = '{5,   3, 32'h0,   1'b0, 5,   11};
    vecs[1] = '{0,   2, 32'h0,   1'b0, 0,   3};
    vecs[2] = '{8,   1, 32'h8E0, 1'b0, 8,   16};
    vecs[3] = '{127, 1, 32'h0,   1'b0, 127, 131};
    vecs[4] = '{6,   2, 32'h0,   1'b1, 6,   11};
    vecs[5] = '{3,   0, 32'h0,   1'b0, 3,   7};

    bus.start = 0; bus.particle_count = '0;
    bus.particle_count_valid = 0; bus.back_pressure = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({bus.busy, bus.done, bus.ref_rd_en, bus.ref_valid, bus.ref_id, bus.ref_rd_addr}), 0);
    rst_n = 1;

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < MAXC; c++) s_bp[c] = (c < 32) ? vecs[i].bp_mask[c] : 1'b0;
      run_cell(vecs[i].count, vecs[i].pcv_delay, vecs[i].extra_start, i, n_reads, done_cyc);
      check($sformatf("vec%0d_reads", i), n_reads, vecs[i].exp_reads);
      check($sformatf("vec%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
    end

    // Abort mid-issue: 4 of 10 reads done, then reset must flush everything.
    n_reads = 0;
    for (int c = 0; c < 6; c++) begin
      bus.start = (c == 0);
      bus.back_pressure = 0;
      bus.particle_count_valid = (c == 1);
      bus.particle_count = W'(10);
      @(negedge clk);
      if (bus.ref_rd_en) n_reads++;
      @(posedge clk); #1;
    end
    check("mid_reset_reads_before", n_reads, 4);
    rst_n = 0;
    bus.start = 0; bus.particle_count_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle%0d", k),
            int'({bus.busy, bus.done, bus.ref_rd_en, bus.ref_valid, bus.ref_id, bus.ref_rd_addr}), 0);
      @(posedge clk); #1;
    end
    last_id = 0;
    for (int c = 0; c < MAXC; c++) s_bp[c] = 0;
    run_cell(3, 1, 1'b0, 100, n_reads, done_cyc);
    check("after_reset_reads", n_reads, 3);
    check("after_reset_done_cycle", done_cyc, 7);

    for (int r = 0; r < 20; r++) begin
      cnt = $urandom_range(0, 40);
      pd = $urandom_range(0, 4);
      extra = 1'($urandom_range(0, 1));
      for (int c = 0; c < MAXC; c++) s_bp[c] = ($urandom_range(0, 2) == 0);
      run_cell(cnt, pd, extra, 200 + r, n_reads, done_cyc);
      check($sformatf("rand%0d_reads", r), n_reads, cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
